vectored_intr_ctrl: RTL and testbench
=====================================

# vectored_intr_ctrl

N-channel vectored interrupt controller placed between peripheral interrupt lines and the pipelined CPU's single `intr`/`inta` pair. It latches and masks requests, resolves fixed priority, and raises `intr`. It presents the winning channel's handler vector, captures the CPU's acknowledge, and tracks in-service state until software issues end-of-interrupt (EOI). It generalises the CPU's single-line interrupt to NCH channels with per-channel edge/level mode and optional nesting.

## Interface
- `NCH`, 8: number of interrupt channels, 2..32
- `VBASE`, 32'h0000_0008: vector of channel 0
- `VSTRIDE`, 4: byte distance between consecutive channel vectors
- `clk`  in  1  rising-edge clock
- `clr`  in  1  reset; synchronous, active-high, sampled on `clk` rising edge
- `irq`  in  NCH  raw interrupt lines, synchronous to `clk`
- `cfg_we`  in  1  register write strobe
- `cfg_addr`  in  2  register select: 0 MASK, 1 MODE, 2 PEND, 3 EOI
- `cfg_wdata`  in  32  write data; bits [NCH-1:0] used
- `cfg_rdata`  out  32  combinational read of the addressed register, zero-extended; EOI reads in-service mask
- `intr`  out  1  registered interrupt request to CPU
- `inta`  in  1  one-cycle CPU acknowledge
- `id`  out  $clog2(NCH)  current winning channel
- `vec`  out  32  VBASE + id*VSTRIDE, valid while `intr`=1

## Operation
- MASK: bit=1 enables the channel. MODE: bit=1 selects edge mode, 0 selects level mode.
- Edge mode: PEND bit sets on any edge where `irq`=1 and previous sample `irq_q`=0. It clears on acknowledge of that channel, or on a PEND write with a 1 in that bit. Set wins over clear in the same cycle.
- Level mode: PEND bit = live `irq` bit. PEND writes are ignored.
- Eligible = PEND & MASK & ~blocked. Without nesting, blocked = all channels while any channel is in service. Lowest index wins.
- FSM states:
  - IDLE: `intr`=0. Goes to REQ when eligible≠0.
  - REQ: `intr`=1. `id`/`vec` track the current winner each cycle. On `inta`=1: capture `id`, set that channel's in-service bit, clear its edge PEND, go to SERV. If eligible falls to 0 before `inta`: go to IDLE.
  - SERV: `intr`=0. An EOI write clears the highest-priority in-service bit. When in-service becomes 0, go to IDLE.
- `inta` outside REQ is ignored.
- EOI with nothing in service is a no-op.
- Masking a channel during REQ withdraws it. It does not affect channels already in service.

## Timing
- Reset values: MASK=0, MODE=0, PEND edge bits=0, in-service=0, `irq_q`=0, state IDLE, `intr`=0, `id`=0, `vec`=VBASE.
- Latency from `irq` sampled high at edge t:
  - Edge-mode PEND=1 after edge t.
  - `intr`=1 after edge t+1.
- Level mode has the same latency, since PEND is live.
- `inta` sampled at edge a → `intr`=0 after edge a.
- Config writes take effect after the write edge.
- `clr` mid-operation returns everything to reset values at that edge, regardless of state or `inta`.

## Configuration
- `INTR_NEST_EN` defined:
  - blocked = channels of equal or lower priority than the highest-priority in-service bit.
  - A higher-priority eligible request raises `intr` from SERV (SERV→REQ).
  - In-service may hold several bits. EOI clears the highest one.
  - When the REQ request is withdrawn, the FSM returns to SERV if in-service≠0, otherwise IDLE.
- `INTR_NEST_EN` undefined: one in-service channel at a time. No preemption.

## Structure
- Shared package `intr_pkg`: register address constants (`INTR_MASK`, `INTR_MODE`, `INTR_PEND`, `INTR_EOI`) and the FSM state enum.
- One sub-module, `intr_prio_enc`: parametrised lowest-index-first priority encoder, outputs `valid` and index. It is used for both eligible selection and EOI in-service selection.

## Test plan
- Reset, then MASK=8'hFF, MODE=8'hFF. Pulse `irq[3]` for one cycle → `intr`=1 two edges later, `id`=3, `vec`=32'h14. `inta` → `intr`=0, PEND[3]=0, EOI read=8'h08.
- Level mode, `irq[5]` held, `inta` never given. Drop `irq[5]` → `intr` falls next cycle, state IDLE, no in-service bit set.
- `irq[6]` and `irq[1]` in the same cycle → `id`=1. After `inta` and EOI → `intr` reasserts with `id`=6.
- Without nesting: `irq[2]` in service, raise `irq[0]` → `intr` stays 0 until EOI, then `id`=0. With `INTR_NEST_EN`: `intr` reasserts during SERV with `id`=0, and in-service=8'h05 after `inta`.
- MASK[4]=0, pulse `irq[4]` → no `intr`, PEND[4]=1. Set MASK[4]=1 → `intr` next cycle. Alternatively write PEND=8'h10 → cleared, no `intr`.
- Assert `clr` during SERV with in-service=8'h02 → all outputs and registers at reset values after that edge. `inta` in IDLE → ignored.

Source files
------------

// File: rtl/intr_pkg.sv
// Shared definitions for the vectored interrupt controller: register map and FSM states.
package intr_pkg;

  localparam logic [1:0] INTR_MASK = 2'd0;
  localparam logic [1:0] INTR_MODE = 2'd1;
  localparam logic [1:0] INTR_PEND = 2'd2;
  localparam logic [1:0] INTR_EOI  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } intr_state_e;

endpackage

// File: rtl/intr_prio_enc.sv
// Lowest-index-first priority encoder; combinational valid flag and winning index.
module intr_prio_enc #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]         req_i,
  output logic                 valid_c,
  output logic [$clog2(N)-1:0] idx_c
);

  localparam int unsigned IW = $clog2(N);

  // Scan from the top down so the lowest set index is the last to write.
  always_comb begin
    valid_c = |req_i;
    idx_c   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req_i[i]) idx_c = IW'(i);
    end
  end

endmodule

// File: rtl/vectored_intr_ctrl.sv
// N-channel vectored interrupt controller feeding a single intr/inta CPU pair.
// Define INTR_NEST_EN to allow higher-priority requests to preempt in-service channels.
module vectored_intr_ctrl
  import intr_pkg::*;
#(
  parameter int unsigned NCH     = 8,
  parameter logic [31:0] VBASE   = 32'h0000_0008,
  parameter int unsigned VSTRIDE = 4
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [NCH-1:0]         irq,
  input  logic                   cfg_we,
  input  logic [1:0]             cfg_addr,
  input  logic [31:0]            cfg_wdata,
  output logic [31:0]            cfg_rdata,
  output logic                   intr,
  input  logic                   inta,
  output logic [$clog2(NCH)-1:0] id,
  output logic [31:0]            vec
);

  localparam int unsigned IDW = $clog2(NCH);

  intr_state_e    state_q, state_d;
  logic [NCH-1:0] irq_q, mask_q, mask_d, mode_q, mode_d, pend_q, pend_d, isr_q, isr_d;
  logic           intr_q, intr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [31:0]    vec_q, vec_d;

  logic [NCH-1:0] pend_live, allow, eligible, win_oh;
  logic           win_valid, isr_valid, ack;
  logic [IDW-1:0] win_idx, isr_idx;
  logic           wr_mask, wr_mode, wr_pend, wr_eoi;

  if (NCH < 32) begin : g_unused
    logic unused_wdata;
    assign unused_wdata = ^cfg_wdata[31:NCH];
  end

  assign wr_mask = cfg_we && (cfg_addr == INTR_MASK);
  assign wr_mode = cfg_we && (cfg_addr == INTR_MODE);
  assign wr_pend = cfg_we && (cfg_addr == INTR_PEND);
  assign wr_eoi  = cfg_we && (cfg_addr == INTR_EOI);

  // Level channels follow the sampled line, giving the same latency as edge channels.
  assign pend_live = (mode_q & pend_q) | (~mode_q & irq_q);

  // Channels that may compete given what is already in service.
  always_comb begin
    allow = '1;
    if (isr_valid) begin
`ifdef INTR_NEST_EN
      for (int i = 0; i < int'(NCH); i++) allow[i] = (IDW'(i) < isr_idx);
`else
      allow = '0;
`endif
    end
  end

  assign eligible = pend_live & mask_q & allow;
  assign win_oh   = NCH'(1) << win_idx;

  intr_prio_enc #(.N(NCH)) u_win_enc (
    .req_i   (eligible),
    .valid_c (win_valid),
    .idx_c   (win_idx)
  );

  intr_prio_enc #(.N(NCH)) u_isr_enc (
    .req_i   (isr_q),
    .valid_c (isr_valid),
    .idx_c   (isr_idx)
  );

  always_comb begin
    state_d = state_q;
    ack     = 1'b0;
    unique case (state_q)
      ST_IDLE: if (win_valid) state_d = ST_REQ;
      ST_REQ: begin
        if (!win_valid) begin
          state_d = (isr_q != '0) ? ST_SERV : ST_IDLE;
        end else if (inta) begin
          state_d = ST_SERV;
          ack     = 1'b1;
        end
      end
      ST_SERV: begin
        if (isr_q == '0) state_d = ST_IDLE;
`ifdef INTR_NEST_EN
        else if (win_valid) state_d = ST_REQ;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    mask_d = wr_mask ? cfg_wdata[NCH-1:0] : mask_q;
    mode_d = wr_mode ? cfg_wdata[NCH-1:0] : mode_q;

    // New edges win over acknowledge and software clears in the same cycle.
    pend_d = (pend_q & ~(ack ? win_oh : '0) & ~(wr_pend ? cfg_wdata[NCH-1:0] : '0))
             | (mode_q & irq & ~irq_q);

    isr_d = isr_q;
    if (wr_eoi && isr_valid) isr_d = isr_d & ~(NCH'(1) << isr_idx);
    if (ack) isr_d = isr_d | win_oh;

    intr_d = (state_d == ST_REQ);
    id_d   = ((state_d == ST_REQ) || ack) ? win_idx : id_q;
    vec_d  = VBASE + 32'(id_d) * VSTRIDE;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      irq_q   <= '0;
      mask_q  <= '0;
      mode_q  <= '0;
      pend_q  <= '0;
      isr_q   <= '0;
      intr_q  <= 1'b0;
      id_q    <= '0;
      vec_q   <= VBASE;
    end else begin
      state_q <= state_d;
      irq_q   <= irq;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      isr_q   <= isr_d;
      intr_q  <= intr_d;
      id_q    <= id_d;
      vec_q   <= vec_d;
    end
  end

  always_comb begin
    cfg_rdata = '0;
    unique case (cfg_addr)
      INTR_MASK: cfg_rdata = 32'(mask_q);
      INTR_MODE: cfg_rdata = 32'(mode_q);
      INTR_PEND: cfg_rdata = 32'(pend_live);
      default:   cfg_rdata = 32'(isr_q);
    endcase
  end

  assign intr = intr_q;
  assign id   = id_q;
  assign vec  = vec_q;

endmodule

// File: tb/tb_vectored_intr_ctrl.sv
// Directed bench for vectored_intr_ctrl: vector table plus multi-cycle corner sequences.
module tb_vectored_intr_ctrl;
  import intr_pkg::*;

  logic        clk = 1'b0;
  logic        clr, cfg_we, inta, intr;
  logic [7:0]  irq;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata, cfg_rdata, vec;
  logic [2:0]  id;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0]  irq;
    logic [7:0]  mask;
    logic [7:0]  mode;
    logic        exp_intr;
    logic [2:0]  exp_id;
    logic [31:0] exp_vec;
    logic [7:0]  exp_isr;
    logic [7:0]  exp_pend;
  } vec_t;

  vec_t tv [8];

  vectored_intr_ctrl #(.NCH(8), .VBASE(32'h0000_0008), .VSTRIDE(4)) dut (
    .clk       (clk),
    .clr       (clr),
    .irq       (irq),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .intr      (intr),
    .inta      (inta),
    .id        (id),
    .vec       (vec)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    cfg_addr = a;
    #1;
    d = cfg_rdata;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(name, d, exp);
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick();
    cfg_we    = 1'b0;
    cfg_wdata = '0;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic wait_intr(input string name, input int budget);
    for (int i = 0; i < budget && !intr; i++) tick();
    chk(name, 32'(intr), 32'd1);
  endtask

  task automatic pulse(input logic [7:0] p);
    irq = p;
    tick();
    irq = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // irq, mask, mode, intr, id, vec, isr after ack, pend after ack
    tv[0] = '{8'h08, 8'hFF, 8'hFF, 1'b1, 3'd3, 32'h14, 8'h08, 8'h00};
    tv[1] = '{8'h42, 8'hFF, 8'hFF, 1'b1, 3'd1, 32'h0C, 8'h02, 8'h40};
    tv[2] = '{8'h10, 8'hEF, 8'hFF, 1'b0, 3'd0, 32'h08, 8'h00, 8'h10};
    tv[3] = '{8'h80, 8'hFF, 8'hFF, 1'b1, 3'd7, 32'h24, 8'h80, 8'h00};
    tv[4] = '{8'hA0, 8'h7F, 8'hFF, 1'b1, 3'd5, 32'h1C, 8'h20, 8'h80};
    tv[5] = '{8'h20, 8'hFF, 8'h00, 1'b1, 3'd5, 32'h1C, 8'h20, 8'h00};
    tv[6] = '{8'h0C, 8'hFF, 8'h04, 1'b1, 3'd2, 32'h10, 8'h04, 8'h00};
    tv[7] = '{8'h00, 8'hFF, 8'hFF, 1'b0, 3'd0, 32'h08, 8'h00, 8'h00};

    clr = 1'b1; irq = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; inta = 1'b0;
    tick();
    tick();
    clr = 1'b0;

    chk("reset intr", 32'(intr), 32'd0);
    chk("reset id", 32'(id), 32'd0);
    chk("reset vec", vec, 32'h08);
    rd_chk("reset mask", INTR_MASK, 32'h0);
    rd_chk("reset mode", INTR_MODE, 32'h0);
    rd_chk("reset pend", INTR_PEND, 32'h0);
    rd_chk("reset isr", INTR_EOI, 32'h0);

    for (int r = 0; r < 8; r++) begin
      do_reset();
      cfg_write(INTR_MASK, 32'(tv[r].mask));
      cfg_write(INTR_MODE, 32'(tv[r].mode));
      irq = tv[r].irq;
      tick();
      tick();
      chk($sformatf("row%0d intr", r), 32'(intr), 32'(tv[r].exp_intr));
      if (tv[r].exp_intr) begin
        chk($sformatf("row%0d id", r), 32'(id), 32'(tv[r].exp_id));
        chk($sformatf("row%0d vec", r), vec, tv[r].exp_vec);
      end
      irq  = '0;
      inta = tv[r].exp_intr;
      tick();
      inta = 1'b0;
      chk($sformatf("row%0d intr after ack", r), 32'(intr), 32'd0);
      rd_chk($sformatf("row%0d isr", r), INTR_EOI, 32'(tv[r].exp_isr));
      rd_chk($sformatf("row%0d pend", r), INTR_PEND, 32'(tv[r].exp_pend));
    end

    // Level request withdrawn before acknowledge.
    do_reset();
    cfg_write(INTR_MASK, 32'hFF);
    cfg_write(INTR_MODE, 32'h00);
    irq = 8'h20;
    tick(); tick();
    chk("level intr", 32'(intr), 32'd1);
    chk("level id", 32'(id), 32'd5);
    tick(); tick(); tick();
    chk("level held intr", 32'(intr), 32'd1);
    irq = '0;
    tick(); tick();
    chk("level withdrawn intr", 32'(intr), 32'd0);
    rd_chk("level withdrawn isr", INTR_EOI, 32'h0);

    // Simultaneous channels 6 and 1, then EOI releases channel 6.
    do_reset();
    cfg_write(INTR_MASK, 32'hFF);
    cfg_write(INTR_MODE, 32'hFF);
    pulse(8'h42);
    tick();
    chk("dual id", 32'(id), 32'd1);
    inta = 1'b1; tick(); inta = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("dual serv intr %0d", i), 32'(intr), 32'd0);
      tick();
    end
    cfg_write(INTR_EOI, 32'h0);
    rd_chk("dual isr after eoi", INTR_EOI, 32'h0);
    wait_intr("dual reassert", 4);
    chk("dual second id", 32'(id), 32'd6);
    chk("dual second vec", vec, 32'h20);

    // Channel 0 raised while channel 2 is in service.
    do_reset();
    cfg_write(INTR_MASK, 32'hFF);
    cfg_write(INTR_MODE, 32'hFF);
    pulse(8'h04);
    tick();
    chk("nest first id", 32'(id), 32'd2);
    inta = 1'b1; tick(); inta = 1'b0;
    pulse(8'h01);
`ifdef INTR_NEST_EN
    wait_intr("nest preempt intr", 3);
    chk("nest preempt id", 32'(id), 32'd0);
    inta = 1'b1; tick(); inta = 1'b0;
    rd_chk("nest isr both", INTR_EOI, 32'h05);
    cfg_write(INTR_EOI, 32'h0);
    rd_chk("nest isr after eoi", INTR_EOI, 32'h04);
`else
    tick();
    chk("no-nest blocked intr a", 32'(intr), 32'd0);
    tick();
    chk("no-nest blocked intr b", 32'(intr), 32'd0);
    rd_chk("no-nest isr", INTR_EOI, 32'h04);
    cfg_write(INTR_EOI, 32'h0);
    wait_intr("no-nest after eoi intr", 4);
    chk("no-nest after eoi id", 32'(id), 32'd0);
`endif

    // Masked request stays pending, then unmask releases it.
    do_reset();
    cfg_write(INTR_MASK, 32'hEF);
    cfg_write(INTR_MODE, 32'hFF);
    pulse(8'h10);
    tick();
    chk("masked intr", 32'(intr), 32'd0);
    rd_chk("masked pend", INTR_PEND, 32'h10);
    cfg_write(INTR_MASK, 32'hFF);
    tick();
    chk("unmask intr", 32'(intr), 32'd1);
    chk("unmask id", 32'(id), 32'd4);

    // Software clear of a masked pending bit.
    do_reset();
    cfg_write(INTR_MASK, 32'hEF);
    cfg_write(INTR_MODE, 32'hFF);
    pulse(8'h10);
    cfg_write(INTR_PEND, 32'h10);
    rd_chk("pend cleared", INTR_PEND, 32'h0);
    cfg_write(INTR_MASK, 32'hFF);
    tick();
    chk("cleared no intr", 32'(intr), 32'd0);

    // Reset during service, then acknowledge while idle.
    do_reset();
    cfg_write(INTR_MASK, 32'hFF);
    cfg_write(INTR_MODE, 32'hFF);
    pulse(8'h02);
    tick();
    inta = 1'b1; tick(); inta = 1'b0;
    rd_chk("pre-clr isr", INTR_EOI, 32'h02);
    pulse(8'h08);
    clr = 1'b1; inta = 1'b1;
    tick();
    clr = 1'b0; inta = 1'b0;
    chk("clr intr", 32'(intr), 32'd0);
    chk("clr id", 32'(id), 32'd0);
    chk("clr vec", vec, 32'h08);
    rd_chk("clr mask", INTR_MASK, 32'h0);
    rd_chk("clr mode", INTR_MODE, 32'h0);
    rd_chk("clr pend", INTR_PEND, 32'h0);
    rd_chk("clr isr", INTR_EOI, 32'h0);
    cfg_write(INTR_MASK, 32'hFF);
    cfg_write(INTR_MODE, 32'hFF);
    inta = 1'b1; tick(); inta = 1'b0;
    tick();
    chk("idle inta intr", 32'(intr), 32'd0);
    rd_chk("idle inta isr", INTR_EOI, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
